// File: rtl/counter_sequencer.sv
// Run/pause/step controller for the LED count register.
// A prescaled tick advances the count while running; one-cycle command
// pulses clear/load the count, toggle run/pause or request a single step.
// COUNT and its Gray-coded twin are registered together so they never skew.
module counter_sequencer #(
    parameter int          WIDTH = 10,
    parameter int          DIV_W = 24,
    parameter logic [31:0] PAT_A = 32'h155,
    parameter logic [31:0] PAT_B = 32'h2AA
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_CLR,
    input  logic             CMD_LDA,
    input  logic             CMD_LDB,
    input  logic             CMD_STEP,
    input  logic             CMD_RUN,
    input  logic             DIR,
    input  logic [1:0]       RATE,
    output logic [WIDTH-1:0] COUNT,
    output logic [WIDTH-1:0] GRAY,
    output logic             RUNNING,
    output logic [1:0]       STATE,
    output logic             TICK,
    output logic             WRAP
);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] PAT_A_W = PAT_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] PAT_B_W = PAT_B[WIDTH-1:0];

    logic [DIV_W-1:0] div_reg;
    logic             prev_bit_reg;
    logic [1:0]       rate_q_reg;
    logic [3:0]       tap;
    logic             sel_bit;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             step_apply;

    // The four selectable prescaler taps are the top four divider bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tap
            assign tap[gi] = div_reg[DIV_W-4+gi];
        end
    endgenerate

    assign sel_bit = tap[rate_q_reg];

    // Rising edge of the selected tap; a RATE change blanks TICK for the
    // cycle in which RATE and its registered copy disagree.
    assign TICK = sel_bit & ~prev_bit_reg & (RATE == rate_q_reg);

    // Free-running prescaler plus edge-detect history and registered rate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_reg      <= '0;
            prev_bit_reg <= 1'b0;
            rate_q_reg   <= 2'd0;
        end else begin
            div_reg      <= div_reg + DIV_W'(1);
            prev_bit_reg <= sel_bit;
            rate_q_reg   <= RATE;
        end
    end

    // Run/pause/step state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_PAUSE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: RUN toggles, STEP only from PAUSE, STEP lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_PAUSE: begin
                if (CMD_RUN) begin
                    state_next = ST_RUN;
                end else if (CMD_STEP) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (CMD_RUN) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_STEP: begin
                state_next = ST_PAUSE;
            end
            default: begin
                state_next = ST_PAUSE;
            end
        endcase
    end

    // Count update: loads beat any step/tick, which is dropped rather than deferred.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        step_apply = 1'b0;
        if (CMD_CLR) begin
            count_next = '0;
        end else if (CMD_LDA) begin
            count_next = PAT_A_W;
        end else if (CMD_LDB) begin
            count_next = PAT_B_W;
        end else begin
            step_apply = (state_reg == ST_STEP) || ((state_reg == ST_RUN) && TICK);
            if (step_apply) begin
                if (DIR) begin
                    count_next = count_reg - WIDTH'(1);
                    wrap_next  = (count_reg == '0);
                end else begin
                    count_next = count_reg + WIDTH'(1);
                    wrap_next  = &count_reg;
                end
            end
        end
        gray_next = count_next ^ (count_next >> 1);
    end

    // Count, Gray twin and wrap pulse all update on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
            gray_reg  <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            gray_reg  <= gray_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign COUNT   = count_reg;
    assign GRAY    = gray_reg;
    assign WRAP    = wrap_reg;
    assign STATE   = state_reg;
    assign RUNNING = (state_reg == ST_RUN);

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized and directed bench for counter_sequencer against a
// cycle-level behavioural model of the count/tick/state rules.
module tb_counter_sequencer;

    localparam int DIV_W = 6;
    localparam int WIDTH = 10;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CMD_CLR;
    logic             CMD_LDA;
    logic             CMD_LDB;
    logic             CMD_STEP;
    logic             CMD_RUN;
    logic             DIR;
    logic [1:0]       RATE;
    logic [WIDTH-1:0] COUNT;
    logic [WIDTH-1:0] GRAY;
    logic             RUNNING;
    logic [1:0]       STATE;
    logic             TICK;
    logic             WRAP;

    always #5 CLK = ~CLK;

    counter_sequencer #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W),
        .PAT_A (32'h155),
        .PAT_B (32'h2AA)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CMD_CLR  (CMD_CLR),
        .CMD_LDA  (CMD_LDA),
        .CMD_LDB  (CMD_LDB),
        .CMD_STEP (CMD_STEP),
        .CMD_RUN  (CMD_RUN),
        .DIR      (DIR),
        .RATE     (RATE),
        .COUNT    (COUNT),
        .GRAY     (GRAY),
        .RUNNING  (RUNNING),
        .STATE    (STATE),
        .TICK     (TICK),
        .WRAP     (WRAP)
    );

    int err_count = 0;
    int chk_count = 0;

    // Reference model state (plain integers).
    int m_div   = 0;
    int m_prev  = 0;
    int m_rate  = 0;
    int m_state = 0;   // 0 pause, 1 run, 2 step
    int m_count = 0;
    int m_wrap  = 0;
    bit m_valid = 1'b0;

    bit tb_dir  = 1'b0;
    int tb_rate = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        chk_count++;
        if (got !== 32'(exp)) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Tick predicted for the coming edge, given the RATE currently driven.
    function automatic bit m_tick(input int rate);
        int b;
        b = (m_div >> (DIV_W - 4 + m_rate)) & 1;
        return (b == 1) && (m_prev == 0) && (rate == m_rate);
    endfunction

    // One clock: drive inputs, compare DUT against model, advance model,
    // then release the pulses and park at the following falling edge.
    task automatic cycle(input bit rst, input bit clr, input bit lda, input bit ldb,
                         input bit step, input bit run, input bit dir, input int rate);
        bit t;
        bit apply;
        int bitv;
        RST = rst; CMD_CLR = clr; CMD_LDA = lda; CMD_LDB = ldb;
        CMD_STEP = step; CMD_RUN = run; DIR = dir; RATE = rate[1:0];
        tb_dir = dir; tb_rate = rate;
        #1;
        t = m_tick(rate);
        if (m_valid) begin
            check_val("count",   32'(COUNT),   m_count);
            check_val("gray",    32'(GRAY),    m_count ^ (m_count >> 1));
            check_val("state",   32'(STATE),   m_state);
            check_val("running", 32'(RUNNING), (m_state == 1) ? 1 : 0);
            check_val("wrap",    32'(WRAP),    m_wrap);
            check_val("tick",    32'(TICK),    t ? 1 : 0);
        end
        if (rst) begin
            m_div = 0; m_prev = 0; m_rate = 0; m_state = 0; m_count = 0; m_wrap = 0;
            m_valid = 1'b1;
        end else begin
            bitv  = (m_div >> (DIV_W - 4 + m_rate)) & 1;
            apply = !(clr || lda || ldb) && (m_state == 2 || (m_state == 1 && t));
            m_wrap = (apply && (dir ? (m_count == 0) : (m_count == MAXV))) ? 1 : 0;
            if (clr)        m_count = 0;
            else if (lda)   m_count = 'h155;
            else if (ldb)   m_count = 'h2AA;
            else if (apply) m_count = (m_count + (dir ? MAXV : 1)) % (MAXV + 1);
            case (m_state)
                0: begin
                    if (run)       m_state = 1;
                    else if (step) m_state = 2;
                end
                1: if (run) m_state = 0;
                default: m_state = 0;
            endcase
            m_prev = bitv;
            m_rate = rate;
            m_div  = (m_div + 1) % (1 << DIV_W);
        end
        if (rst || clr || lda || ldb || step || run)
            $display("txn t=%0t rst=%0b clr=%0b lda=%0b ldb=%0b step=%0b run=%0b dir=%0b rate=%0d tick=%0b -> count=0x%0h state=%0d",
                     $time, rst, clr, lda, ldb, step, run, dir, rate, t, m_count, m_state);
        @(posedge CLK);
        #1;
        RST = 1'b0; CMD_CLR = 1'b0; CMD_LDA = 1'b0; CMD_LDB = 1'b0;
        CMD_STEP = 1'b0; CMD_RUN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, tb_dir, tb_rate);
    endtask

    // Wait (bounded) for a predicted tick, then issue the loads in that cycle.
    task automatic load_on_tick(input bit clr, input bit lda, input bit ldb);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_tick(tb_rate)) begin
                found = 1'b1;
                cycle(0, clr, lda, ldb, 0, 0, tb_dir, tb_rate);
            end else begin
                cycle(0, 0, 0, 0, 0, 0, tb_dir, tb_rate);
            end
        end
        check_val("tick_found", 32'(found), 1);
    endtask

    initial begin
        RST = 1'b1; CMD_CLR = 1'b0; CMD_LDA = 1'b0; CMD_LDB = 1'b0;
        CMD_STEP = 1'b0; CMD_RUN = 1'b0; DIR = 1'b0; RATE = 2'd0;
        @(negedge CLK);

        // Reset and idle: count stays 0, ticks pulse but nothing moves.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(40);
        check_val("idle_count", 32'(COUNT), 0);
        check_val("idle_state", 32'(STATE), 0);
        check_val("idle_running", 32'(RUNNING), 0);

        // Run up for 33 cycles: four ticks land, then pause holds the count.
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        check_val("run_running", 32'(RUNNING), 1);
        idle(33);
        check_val("run_count4", 32'(COUNT), 4);
        check_val("run_gray6", 32'(GRAY), 6);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        check_val("pause_state", 32'(STATE), 0);
        check_val("pause_count", 32'(COUNT), 4);
        idle(10);
        check_val("pause_hold", 32'(COUNT), 4);

        // Step down from 0 wraps to all-ones with a one-cycle WRAP pulse.
        cycle(0, 1, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 1, 0);
        check_val("step_state2", 32'(STATE), 2);
        check_val("step_count0", 32'(COUNT), 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        check_val("step_count", 32'(COUNT), 'h3FF);
        check_val("step_gray", 32'(GRAY), 'h200);
        check_val("step_wrap", 32'(WRAP), 1);
        check_val("step_back", 32'(STATE), 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        check_val("wrap_once", 32'(WRAP), 0);

        // Loads coincident with ticks while running: tick dropped.
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        load_on_tick(0, 1, 0);
        check_val("lda_tick", 32'(COUNT), 'h155);
        load_on_tick(0, 0, 1);
        check_val("ldb_tick", 32'(COUNT), 'h2AA);
        load_on_tick(1, 0, 0);
        check_val("clr_tick", 32'(COUNT), 0);
        load_on_tick(0, 1, 0);
        load_on_tick(1, 1, 1);
        check_val("all_tick", 32'(COUNT), 0);
        check_val("load_running", 32'(RUNNING), 1);

        // Load during STEP discards the step; RUN beats STEP in PAUSE.
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        check_val("p5_step", 32'(STATE), 2);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        check_val("p5_ldb", 32'(COUNT), 'h2AA);
        check_val("p5_pause", 32'(STATE), 0);
        cycle(0, 0, 0, 0, 1, 1, 0, 0);
        check_val("p5_runwin", 32'(STATE), 1);
        check_val("p5_nostep", 32'(COUNT), 'h2AA);

        // Rate change 0->3 while running, then reset mid-run.
        idle(5);
        RATE = 2'd3;
        #1;
        check_val("rate_sup", 32'(TICK), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 3);
        idle(200);
        cycle(1, 0, 0, 0, 0, 0, 0, 3);
        check_val("rst_count", 32'(COUNT), 0);
        check_val("rst_gray", 32'(GRAY), 0);
        check_val("rst_state", 32'(STATE), 0);
        check_val("rst_running", 32'(RUNNING), 0);
        check_val("rst_wrap", 32'(WRAP), 0);
        check_val("rst_tick", 32'(TICK), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit r_rst, r_clr, r_lda, r_ldb, r_step, r_run, r_dir;
            int r_rate;
            r_rst  = ($urandom_range(0, 299) == 0);
            r_clr  = ($urandom_range(0, 29) == 0);
            r_lda  = ($urandom_range(0, 29) == 0);
            r_ldb  = ($urandom_range(0, 29) == 0);
            r_step = ($urandom_range(0, 11) == 0);
            r_run  = ($urandom_range(0, 15) == 0);
            r_dir  = ($urandom_range(0, 31) == 0) ? !tb_dir : tb_dir;
            r_rate = ($urandom_range(0, 63) == 0) ? int'($urandom_range(0, 3)) : tb_rate;
            if (r_rate > 1 && $urandom_range(0, 1) == 0) r_rate = 0;
            cycle(r_rst, r_clr, r_lda, r_ldb, r_step, r_run, r_dir, r_rate);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that owns and sequences the board's 10-bit LED count register. It replaces the ad-hoc async-reset counter with a single-clock, synchronous design.
- Takes one-cycle command pulses (from debouncer PB_down outputs) and a selectable prescaler tick. It arbitrates between them with fixed priority and runs a small run/pause/step state machine.
- Drives COUNT and its Gray-coded twin to the LED banks, plus RUNNING and WRAP status to the activity LEDs.

Parameters:
- WIDTH, 10, count register width.
- DIV_W, 24, prescaler width; must be >= 4.
- PAT_A, 10'h155, value loaded by CMD_LDA; truncated to WIDTH.
- PAT_B, 10'h2AA, value loaded by CMD_LDB; truncated to WIDTH.

Ports:
- CLK  input  1  system clock; all state is on its rising edge.
- RST  input  1  synchronous reset, active-high.
- CMD_CLR  input  1  one-cycle pulse; load 0.
- CMD_LDA  input  1  one-cycle pulse; load PAT_A.
- CMD_LDB  input  1  one-cycle pulse; load PAT_B.
- CMD_STEP  input  1  one-cycle pulse; single step while paused.
- CMD_RUN  input  1  one-cycle pulse; toggle run/pause.
- DIR  input  1  0 = count up, 1 = count down; sampled every cycle.
- RATE  input  2  tick rate select; 0 = fastest.
- COUNT  output  WIDTH  registered count value.
- GRAY  output  WIDTH  registered Gray code of COUNT, cycle-aligned with COUNT.
- RUNNING  output  1  1 when state is RUN.
- STATE  output  2  0 = PAUSE, 1 = RUN, 2 = STEP.
- TICK  output  1  internal tick pulse, combinational from registers.
- WRAP  output  1  registered one-cycle pulse on count wrap.

Behaviour:
- Reset (RST=1 at a clock edge) overrides everything:
  - COUNT=0, GRAY=0, STATE=PAUSE, WRAP=0.
  - Prescaler div=0, prev_bit=0, rate_q=0.
  - Consequently TICK=0 and RUNNING=0.
  - Reset mid-STEP discards the step.
- Prescaler:
  - div increments by 1 every cycle and wraps modulo 2^DIV_W.
  - rate_q registers RATE each cycle.
  - Selected bit index k = DIV_W-4+rate_q.
  - prev_bit registers div[k] each cycle.
  - TICK = div[k] & ~prev_bit & (RATE == rate_q). A rate change therefore suppresses TICK for exactly one cycle and never yields a spurious tick.
  - Steady-state tick period is 2^(k+1) cycles.
- FSM:
  - PAUSE:
    - CMD_RUN -> RUN.
    - Otherwise CMD_STEP -> STEP.
    - CMD_RUN wins over CMD_STEP in the same cycle.
  - RUN:
    - CMD_RUN -> PAUSE.
    - CMD_STEP is ignored.
  - STEP:
    - Unconditionally -> PAUSE after one cycle.
    - CMD_RUN and CMD_STEP are ignored.
- Count update, evaluated once per cycle with priority CLR > LDA > LDB > step/tick:
  - A load/clear command takes effect at the edge where it is sampled and leaves STATE transitions unaffected, except CLR/LDA/LDB in STEP, which discard the pending step (state still -> PAUSE).
  - In STEP with no load: COUNT ± 1 per DIR at that edge. Step latency is CMD_STEP sampled at edge n, STATE=STEP after n, COUNT changes at n+1.
  - In RUN with TICK=1 and no load: COUNT ± 1 at that edge.
  - A tick coincident with any load is dropped, not deferred.
  - A tick in PAUSE or STEP is ignored.
- Arithmetic: modulo 2^WIDTH.
- WRAP:
  - Next-edge pulse when an increment/decrement moves COUNT from all-ones to 0 (up) or from 0 to all-ones (down).
  - Loads never assert WRAP.
- GRAY is computed from the next-count value (n ^ (n >> 1)) and registered alongside COUNT, so both outputs change on the same edge.
- Simultaneous CMD_RUN plus a tick in RUN: state -> PAUSE and the tick is still applied that cycle (the decision uses the current state).

Test Plan (bench uses DIV_W=6, so RATE 0 selects bit 2 with tick period 8):
1. Reset then idle 40 cycles -> COUNT=0, GRAY=0, STATE=0, TICK still pulses every 8 cycles (first when div=4), RUNNING=0.
2. CMD_RUN pulse, DIR=0, RATE=0, run 33 cycles -> RUNNING=1, COUNT increments once per TICK reaching 4, GRAY=6 at COUNT=4. Second CMD_RUN -> STATE=0 and COUNT holds.
3. From paused COUNT=0, DIR=1, CMD_STEP -> STATE=2 for one cycle, then COUNT=0x3FF, GRAY=0x200, WRAP high exactly one cycle, STATE=0.
4. CMD_LDA, CMD_LDB and CMD_CLR pulses each issued in the same cycle as a TICK while running -> COUNT becomes 0x155, 0x2AA and 0 respectively with no +1. All three asserted together -> COUNT=0.
5. CMD_STEP in PAUSE, then CMD_LDB on the next cycle (while STATE=2) -> COUNT=0x2AA (step discarded) and STATE=0. Separately, CMD_RUN with CMD_STEP together in PAUSE -> STATE=1 with no step applied.
6. Running with RATE changed 0->3 -> TICK=0 in the cycle after the change, next tick arrives on the rising edge of div[5], and period is then 64 cycles. Asserting RST mid-run -> all outputs return to reset values on the next edge.
